shifter_arbiter: RTL and testbench

//  Shares the single combinational shifter between two requesters: port 0 is the
//  EX-stage shift path, port 1 the multicycle/aux unit. Each port has its own

---
 rtl/shifter_arbiter.sv | 118 +++++++++++
 tb/tb_shifter_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_arbiter.sv
// Two-port arbiter in front of a shared combinational shifter. Each port owns a
// one-entry registered response slot; at most one request is granted per cycle.
module shifter_arbiter #(
   parameter int DATA_W  = 32,
   parameter int SHAMT_W = 5,
   parameter int OP_W    = 3,
   parameter int RR_EN   = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [DATA_W-1:0]  req0_rs,
   input  logic [DATA_W-1:0]  req0_rt,
   input  logic [SHAMT_W-1:0] req0_shamt,
   input  logic [OP_W-1:0]    req0_op,
   output logic               rsp0_valid,
   input  logic               rsp0_ready,
   output logic [DATA_W-1:0]  rsp0_data,
   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [DATA_W-1:0]  req1_rs,
   input  logic [DATA_W-1:0]  req1_rt,
   input  logic [SHAMT_W-1:0] req1_shamt,
   input  logic [OP_W-1:0]    req1_op,
   output logic               rsp1_valid,
   input  logic               rsp1_ready,
   output logic [DATA_W-1:0]  rsp1_data,
   output logic [DATA_W-1:0]  sh_rs,
   output logic [DATA_W-1:0]  sh_rt,
   output logic [SHAMT_W-1:0] sh_shamt,
   output logic [OP_W-1:0]    sh_op,
   input  logic [DATA_W-1:0]  sh_out
);

   logic              slot_free0, slot_free1;
   logic              elig0, elig1;
   logic              grant0, grant1;
   logic              rsp0_valid_q, rsp0_valid_d;
   logic              rsp1_valid_q, rsp1_valid_d;
   logic [DATA_W-1:0] rsp0_data_q, rsp0_data_d;
   logic [DATA_W-1:0] rsp1_data_q, rsp1_data_d;
   logic              rr_ptr_q, rr_ptr_d;

   // A slot draining this cycle counts as free, so a full slot refills without a bubble.
   always_comb begin
      slot_free0 = !rsp0_valid_q || rsp0_ready;
      slot_free1 = !rsp1_valid_q || rsp1_ready;
      elig0      = req0_valid && slot_free0 && !rst;
      elig1      = req1_valid && slot_free1 && !rst;
      grant0     = elig0;
      grant1     = elig1;
      if (elig0 && elig1) begin
         grant1 = (RR_EN != 0) && rr_ptr_q;
         grant0 = !grant1;
      end
   end

   always_comb begin
      sh_rs    = '0;
      sh_rt    = '0;
      sh_shamt = '0;
      sh_op    = '0;
      if (grant0) begin
         sh_rs    = req0_rs;
         sh_rt    = req0_rt;
         sh_shamt = req0_shamt;
         sh_op    = req0_op;
      end else if (grant1) begin
         sh_rs    = req1_rs;
         sh_rt    = req1_rt;
         sh_shamt = req1_shamt;
         sh_op    = req1_op;
      end
   end

   always_comb begin
      rsp0_valid_d = rsp0_valid_q && !rsp0_ready;
      rsp1_valid_d = rsp1_valid_q && !rsp1_ready;
      rsp0_data_d  = rsp0_data_q;
      rsp1_data_d  = rsp1_data_q;
      rr_ptr_d     = rr_ptr_q;
      if (grant0) begin
         rsp0_valid_d = 1'b1;
         rsp0_data_d  = sh_out;
      end
      if (grant1) begin
         rsp1_valid_d = 1'b1;
         rsp1_data_d  = sh_out;
      end
      // Pointer moves to the port that did not just win.
      if ((RR_EN != 0) && (grant0 || grant1)) rr_ptr_d = grant0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_data_q  <= '0;
         rsp1_data_q  <= '0;
         rr_ptr_q     <= 1'b0;
      end else begin
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
         rsp0_data_q  <= rsp0_data_d;
         rsp1_data_q  <= rsp1_data_d;
         rr_ptr_q     <= rr_ptr_d;
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign rsp0_valid = rsp0_valid_q;
   assign rsp1_valid = rsp1_valid_q;
   assign rsp0_data  = rsp0_data_q;
   assign rsp1_data  = rsp1_data_q;

endmodule

// File: tb/tb_shifter_arbiter.sv
// Bench for shifter_arbiter: a round-robin and a fixed-priority instance, each with
// a behavioural shifter, directed then random traffic, and a response scoreboard.
module tb_shifter_arbiter;

   typedef struct packed {
      logic [31:0] rs;
      logic [31:0] rt;
      logic [4:0]  sa;
      logic [2:0]  op;
   } req_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        v    [2][2] = '{default: 1'b0};
   logic        rin  [2][2] = '{default: 1'b0};
   logic        acc  [2][2] = '{default: 1'b0};
   logic [31:0] rs   [2][2] = '{default: '0};
   logic [31:0] rt   [2][2] = '{default: '0};
   logic [4:0]  sa   [2][2] = '{default: '0};
   logic [2:0]  op   [2][2] = '{default: '0};
   logic        rdy  [2][2];
   logic        rv   [2][2];
   logic [31:0] rd   [2][2];
   logic [31:0] shrs [2];
   logic [31:0] shrt [2];
   logic [31:0] shout[2];
   logic [4:0]  shsa [2];
   logic [2:0]  shop [2];

   logic        mfull[2][2] = '{default: 1'b0};
   logic [31:0] mdata[2][2] = '{default: '0};
   logic        mrr  [2]    = '{default: 1'b0};
   logic [31:0] exp_q[4][$];
   req_t        sq[4][$];

   bit          rand_mode = 1'b0;
   logic [1:0]  force_rdy = 2'b11;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   // MIPS-style shift decode; reserved codes give a distinctive non-shift value.
   function automatic logic [31:0] shf(input logic [31:0] a, input logic [31:0] b,
                                       input logic [4:0] s, input logic [2:0] o);
      case (o)
         3'b000:  return b << s;
         3'b010:  return b >> s;
         3'b011:  return 32'($signed(b) >>> s);
         3'b100:  return b << a[4:0];
         3'b110:  return b >> a[4:0];
         3'b111:  return 32'($signed(b) >>> a[4:0]);
         default: return ~b ^ {o, 29'd0};
      endcase
   endfunction

   for (genvar k = 0; k < 2; k++) begin : g_dut
      shifter_arbiter #(.DATA_W(32), .SHAMT_W(5), .OP_W(3), .RR_EN((k == 0) ? 1 : 0)) u_dut (
         .clk(clk), .rst(rst),
         .req0_valid(v[k][0]), .req0_ready(rdy[k][0]), .req0_rs(rs[k][0]), .req0_rt(rt[k][0]),
         .req0_shamt(sa[k][0]), .req0_op(op[k][0]),
         .rsp0_valid(rv[k][0]), .rsp0_ready(rin[k][0]), .rsp0_data(rd[k][0]),
         .req1_valid(v[k][1]), .req1_ready(rdy[k][1]), .req1_rs(rs[k][1]), .req1_rt(rt[k][1]),
         .req1_shamt(sa[k][1]), .req1_op(op[k][1]),
         .rsp1_valid(rv[k][1]), .rsp1_ready(rin[k][1]), .rsp1_data(rd[k][1]),
         .sh_rs(shrs[k]), .sh_rt(shrt[k]), .sh_shamt(shsa[k]), .sh_op(shop[k]), .sh_out(shout[k])
      );
      assign shout[k] = shf(shrs[k], shrt[k], shsa[k], shop[k]);
   end

   task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Requester/consumer driver: a request not yet accepted is held stable.
   always @(posedge clk) begin : drv
      req_t r;
      #1;
      for (int k = 0; k < 2; k++) begin
         for (int p = 0; p < 2; p++) begin
            if (!(v[k][p] && !acc[k][p])) begin
               v[k][p] = 1'b0;
               if (sq[k*2+p].size() != 0) begin
                  r = sq[k*2+p].pop_front();
                  v[k][p] = 1'b1;
               end else if (rand_mode && ($urandom_range(0, 1) == 1)) begin
                  r = {$urandom, $urandom, 5'($urandom), 3'($urandom)};
                  v[k][p] = 1'b1;
               end
               if (v[k][p]) begin
                  rs[k][p] = r.rs;
                  rt[k][p] = r.rt;
                  sa[k][p] = r.sa;
                  op[k][p] = r.op;
               end
            end
            rin[k][p] = rand_mode ? ($urandom_range(0, 3) != 0) : force_rdy[p];
         end
      end
   end

   // Reference model: slot occupancy, pointer and grant rules; pushes expected results.
   always @(negedge clk) begin : model
      logic        e [2];
      logic        g [2];
      logic [71:0] sh_exp;
      for (int k = 0; k < 2; k++) begin
         for (int p = 0; p < 2; p++) e[p] = !rst && v[k][p] && (!mfull[k][p] || rin[k][p]);
         g[0] = e[0];
         g[1] = e[1];
         if (e[0] && e[1]) begin
            g[1] = (k == 0) ? mrr[k] : 1'b0;
            g[0] = !g[1];
         end
         sh_exp = '0;
         for (int p = 0; p < 2; p++) begin
            chk($sformatf("i%0d p%0d req_ready", k, p), 72'(rdy[k][p]), 72'(g[p]));
            chk($sformatf("i%0d p%0d rsp_valid", k, p), 72'(rv[k][p]), 72'(mfull[k][p]));
            chk($sformatf("i%0d p%0d rsp_data", k, p), 72'(rd[k][p]), 72'(mdata[k][p]));
            if (g[p]) sh_exp = {rs[k][p], rt[k][p], sa[k][p], op[k][p]};
            acc[k][p] = v[k][p] && rdy[k][p];
         end
         chk($sformatf("i%0d grant_onehot", k), 72'(rdy[k][0] && rdy[k][1]), 72'(0));
         chk($sformatf("i%0d sh_drive", k), {shrs[k], shrt[k], shsa[k], shop[k]}, sh_exp);
         if (rst) begin
            mrr[k] = 1'b0;
            for (int p = 0; p < 2; p++) begin
               mfull[k][p] = 1'b0;
               mdata[k][p] = '0;
               exp_q[k*2+p].delete();
            end
         end else begin
            for (int p = 0; p < 2; p++) begin
               if (g[p]) begin
                  mfull[k][p] = 1'b1;
                  mdata[k][p] = shf(rs[k][p], rt[k][p], sa[k][p], op[k][p]);
                  exp_q[k*2+p].push_back(mdata[k][p]);
               end else if (rin[k][p]) begin
                  mfull[k][p] = 1'b0;
               end
            end
            if ((k == 0) && (g[0] || g[1])) mrr[k] = g[0];
         end
      end
   end

   // Scoreboard monitor: every consumed response must match the oldest expectation.
   always @(negedge clk) begin : mon
      if (!rst) begin
         for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) begin
               if (rv[k][p] && rin[k][p]) begin
                  if (exp_q[k*2+p].size() == 0) begin
                     n_cmp++;
                     n_err++;
                     $display("FAIL i%0d p%0d unexpected_rsp: got %h expected none", k, p, rd[k][p]);
                  end else begin
                     chk($sformatf("i%0d p%0d sb_data", k, p), 72'(rd[k][p]),
                         72'(exp_q[k*2+p].pop_front()));
                  end
               end
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic push2(input int p, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] s, input logic [2:0] o);
      req_t r;
      r = {a, b, s, o};
      sq[p].push_back(r);
      sq[2+p].push_back(r);
   endtask

   function automatic bit busy();
      bit b = 1'b0;
      for (int i = 0; i < 4; i++) if (sq[i].size() != 0) b = 1'b1;
      for (int k = 0; k < 2; k++)
         for (int p = 0; p < 2; p++) if (v[k][p]) b = 1'b1;
      return b;
   endfunction

   task automatic wait_idle(input int maxc);
      int c = 0;
      while (busy() && (c < maxc)) begin
         step(1);
         c++;
      end
      if (c >= maxc) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_idle: got timeout after %0d cycles expected idle", c);
      end
      step(2);
   endtask

   initial begin
      step(3);
      rst = 1'b0;
      // Port 0 alone: sll / srl / sra with the reference operands.
      push2(0, 32'hFF00F000, 32'hFF000002, 5'd6, 3'b000);
      push2(0, 32'hFF00F000, 32'hFF000002, 5'd6, 3'b010);
      push2(0, 32'hFF00F000, 32'hFF000002, 5'd6, 3'b011);
      wait_idle(50);
      push2(1, 32'hFF00F000, 32'hFF000002, 5'd6, 3'b100);
      wait_idle(50);
      // Contention: both ports valid together.
      for (int i = 0; i < 4; i++) begin
         push2(0, 32'hFF00F000, 32'hFF000002, 5'(i + 1), 3'b000);
         push2(1, 32'hFF00F000, 32'hFF000002, 5'(i + 2), 3'b010);
      end
      wait_idle(50);
      // Stall port 0's consumer while port 1 streams, then release.
      force_rdy = 2'b10;
      for (int i = 0; i < 3; i++) push2(0, 32'h0000_0003, 32'h8000_1234 + 32'(i), 5'(i), 3'b011);
      for (int i = 0; i < 6; i++) push2(1, 32'h0000_0004 + 32'(i), 32'h1234_5678, 5'd0, 3'b110);
      step(8);
      force_rdy = 2'b11;
      wait_idle(50);
      // Back-to-back on port 0, including reserved opcodes.
      for (int i = 0; i < 6; i++) push2(0, 32'h0000_0011, 32'hA5A5_0000 + 32'(i), 5'd3, 3'(i));
      wait_idle(50);
      // Reset while both slots are full.
      force_rdy = 2'b00;
      push2(0, 32'hFF00F000, 32'hFF000002, 5'd6, 3'b000);
      push2(1, 32'hFF00F000, 32'hFF000002, 5'd6, 3'b011);
      step(4);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      force_rdy = 2'b11;
      push2(0, 32'h0, 32'h0000_00F0, 5'd4, 3'b010);
      push2(1, 32'h0, 32'h0000_00F0, 5'd1, 3'b000);
      wait_idle(50);
      // Random traffic with back-pressure and occasional resets.
      rand_mode = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         step(1);
         rst = ($urandom_range(0, 299) == 0);
      end
      rst = 1'b0;
      rand_mode = 1'b0;
      wait_idle(100);
      step(3);
      for (int i = 0; i < 4; i++) chk($sformatf("q%0d leftover", i), 72'(exp_q[i].size()), 72'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
